// File: rtl/isa_pkg.sv
// isa_pkg: opcode encoding, field-offset helpers and operand-usage lookups for the
// 16-bit / 8-opcode ISA. The lookup functions are shared with the execute stage, so
// they take only the opcode and carry no datapath width.
package isa_pkg;

  typedef enum logic [2:0] {
    SET   = 3'd0,  // rd <- imm
    LDPX  = 3'd1,  // rd <- [rs1]
    MODEX = 3'd2,  // rd <- f(rs1, rs2)
    STPX  = 3'd3,  // [rs1] <- rd, no register write
    CMPEQ = 3'd4,  // rd <- (rs1 == rs2)
    JEQ   = 3'd5,  // conditional jump to addr
    J     = 3'd6,  // jump to addr
    ADD   = 3'd7   // rd <- rd + imm
  } opcode_e;

  // Field positions, opcode in the top OPC_W bits, then rd, rs1, rs2.
  function automatic int unsigned rd_msb(input int unsigned arq, input int unsigned opc_w);
    return arq - opc_w - 1;
  endfunction

  function automatic int unsigned rs1_msb(input int unsigned arq, input int unsigned opc_w,
                                          input int unsigned reg_w);
    return arq - opc_w - reg_w - 1;
  endfunction

  function automatic int unsigned rs2_msb(input int unsigned arq, input int unsigned opc_w,
                                          input int unsigned reg_w);
    return arq - opc_w - 2 * reg_w - 1;
  endfunction

  function automatic int unsigned addr_width(input int unsigned arq, input int unsigned opc_w);
    return arq - opc_w;
  endfunction

  function automatic int unsigned imm_width(input int unsigned arq, input int unsigned opc_w,
                                            input int unsigned reg_w);
    return arq - opc_w - reg_w;
  endfunction

  function automatic bit reads_rd(input opcode_e op);
    return op inside {STPX, ADD};
  endfunction

  function automatic bit reads_rs1(input opcode_e op);
    return op inside {LDPX, MODEX, STPX, CMPEQ};
  endfunction

  function automatic bit reads_rs2(input opcode_e op);
    return op inside {MODEX, CMPEQ};
  endfunction

  function automatic bit writes_rd(input opcode_e op);
    return op inside {SET, LDPX, MODEX, CMPEQ, ADD};
  endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// instr_decode_stage_if: fetch-side and execute-side handshakes of the decode stage,
// plus the writeback retire port and flush.
//   slave  : the decode stage (consumes instr/out_ready/wb/flush, drives in_ready/out_*)
//   master : the surrounding pipeline or a testbench driving the stage
interface instr_decode_stage_if #(
  parameter int unsigned ARQ    = 16,
  parameter int unsigned OPC_W  = 3,
  parameter int unsigned REG_W  = 3,
  parameter int unsigned DATA_W = 16
);

  logic                 in_valid;
  logic                 in_ready;
  logic [ARQ-1:0]       instr;
  logic                 out_valid;
  logic                 out_ready;
  logic [OPC_W-1:0]     out_opcode;
  logic [REG_W-1:0]     out_rd;
  logic [REG_W-1:0]     out_rs1;
  logic [REG_W-1:0]     out_rs2;
  logic [ARQ-OPC_W-1:0] out_addr;
  logic [DATA_W-1:0]    out_imm;
  logic                 out_wr_en;
  logic                 out_illegal;
  logic                 wb_valid;
  logic [REG_W-1:0]     wb_rd;
  logic                 flush;

  modport slave (
    input  in_valid, instr, out_ready, wb_valid, wb_rd, flush,
    output in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2, out_addr, out_imm,
           out_wr_en, out_illegal
  );

  modport master (
    output in_valid, instr, out_ready, wb_valid, wb_rd, flush,
    input  in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2, out_addr, out_imm,
           out_wr_en, out_illegal
  );

endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: one pending-write bit per architectural register.
//   clk_i, rst_ni      : clock, asynchronous active-low reset (clears all bits)
//   set_i, set_rd_i    : mark a register as having a write in flight
//   clr_i, clr_rd_i    : writeback retired that register
//   busy_o             : registered busy vector
// A set and clear of the same register in one cycle leaves it busy: the newly issued
// write is younger than the one retiring.
module reg_scoreboard #(
  parameter int unsigned REG_W = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  set_i,
  input  logic [REG_W-1:0]      set_rd_i,
  input  logic                  clr_i,
  input  logic [REG_W-1:0]      clr_rd_i,
  output logic [2**REG_W-1:0]   busy_o
);

  logic [2**REG_W-1:0] busy_d, busy_q;

  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_rd_i] = 1'b0;
    if (set_i) busy_d[set_rd_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered decode between fetch and execute.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instr_decode_stage_if.slave - fetch handshake (in_valid/in_ready/instr),
//                execute handshake (out_valid/out_ready/out_*), writeback retire
//                (wb_valid/wb_rd) and flush
// Splits the instruction into fields, stalls on read-after-write hazards using a register
// scoreboard plus the held instruction, and holds the result in one output register.
module instr_decode_stage
  import isa_pkg::*;
#(
  parameter int unsigned ARQ        = 16,
  parameter int unsigned OPC_W      = 3,
  parameter int unsigned REG_W      = 3,
  parameter int unsigned DATA_W     = 16,
  parameter bit          IMM_SIGNED = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  instr_decode_stage_if.slave bus
);

  localparam int unsigned RdMsb  = rd_msb(ARQ, OPC_W);
  localparam int unsigned Rs1Msb = rs1_msb(ARQ, OPC_W, REG_W);
  localparam int unsigned Rs2Msb = rs2_msb(ARQ, OPC_W, REG_W);
  localparam int unsigned AddrW  = addr_width(ARQ, OPC_W);
  localparam int unsigned ImmW   = imm_width(ARQ, OPC_W, REG_W);
  localparam int unsigned NRegs  = 2**REG_W;

  // Raw fields straight from the instruction word
  logic [OPC_W-1:0]  opc_raw;
  opcode_e           op;
  logic              illegal;
  logic [REG_W-1:0]  raw_rd, raw_rs1, raw_rs2;
  logic [AddrW-1:0]  raw_addr;
  logic [ImmW-1:0]   raw_imm;
  logic [DATA_W-1:0] imm_ext;

  assign opc_raw  = bus.instr[ARQ-1 -: OPC_W];
  assign op       = opcode_e'(opc_raw[2:0]);
  assign raw_rd   = bus.instr[RdMsb -: REG_W];
  assign raw_rs1  = bus.instr[Rs1Msb -: REG_W];
  assign raw_rs2  = bus.instr[Rs2Msb -: REG_W];
  assign raw_addr = bus.instr[AddrW-1:0];
  assign raw_imm  = bus.instr[ImmW-1:0];

  // Only opcodes beyond the 8 defined ones are illegal; a 3-bit field can't hold one.
  if (OPC_W > 3) begin : g_wide_opc
    assign illegal = |opc_raw[OPC_W-1:3];
  end else begin : g_narrow_opc
    assign illegal = 1'b0;
  end

  always_comb begin
    if (IMM_SIGNED) imm_ext = DATA_W'($signed(raw_imm));
    else            imm_ext = DATA_W'(raw_imm);
  end

  // Decoded fields; fields the opcode does not use are forced to 0
  logic [OPC_W-1:0]  dec_opcode;
  logic [REG_W-1:0]  dec_rd, dec_rs1, dec_rs2;
  logic [AddrW-1:0]  dec_addr;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_wr_en;

  always_comb begin
    dec_opcode = '0;
    dec_rd     = '0;
    dec_rs1    = '0;
    dec_rs2    = '0;
    dec_addr   = '0;
    dec_imm    = '0;
    dec_wr_en  = 1'b0;
    if (!illegal) begin
      dec_opcode = opc_raw;
      dec_wr_en  = writes_rd(op);
      unique case (op)
        SET, ADD: begin
          // rd doubles as the source for ADD; the imm field overlaps rs1/rs2
          dec_rd  = raw_rd;
          dec_rs1 = raw_rd;
          dec_imm = imm_ext;
        end
        LDPX, STPX: begin
          dec_rd  = raw_rd;
          dec_rs1 = raw_rs1;
        end
        MODEX, CMPEQ: begin
          dec_rd  = raw_rd;
          dec_rs1 = raw_rs1;
          dec_rs2 = raw_rs2;
        end
        JEQ, J: begin
          dec_addr = raw_addr;
        end
      endcase
    end
  end

  // Output register bank
  logic              out_valid_d, out_valid_q;
  logic [OPC_W-1:0]  out_opcode_d, out_opcode_q;
  logic [REG_W-1:0]  out_rd_d, out_rd_q;
  logic [REG_W-1:0]  out_rs1_d, out_rs1_q;
  logic [REG_W-1:0]  out_rs2_d, out_rs2_q;
  logic [AddrW-1:0]  out_addr_d, out_addr_q;
  logic [DATA_W-1:0] out_imm_d, out_imm_q;
  logic              out_wr_en_d, out_wr_en_q;
  logic              out_illegal_d, out_illegal_q;

  // Hazard detection: scoreboard bits are registered, so a writeback clears the stall
  // only from the following cycle. The held instruction counts as a pending write too.
  logic [NRegs-1:0] sb_busy, busy_vec;
  logic             hazard, in_ready, accept, issue;

  always_comb begin
    busy_vec = sb_busy;
    if (out_valid_q && out_wr_en_q) busy_vec[out_rd_q] = 1'b1;
  end

  assign hazard = bus.in_valid & ~illegal &
                  ((reads_rd(op)  & busy_vec[raw_rd])  |
                   (reads_rs1(op) & busy_vec[raw_rs1]) |
                   (reads_rs2(op) & busy_vec[raw_rs2]));

  assign in_ready = rst_n & ~bus.flush & ~hazard & (~out_valid_q | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;
  // A flushed instruction never issues, so it never claims a scoreboard bit.
  assign issue    = out_valid_q & bus.out_ready & out_wr_en_q & ~bus.flush;

  reg_scoreboard #(
    .REG_W (REG_W)
  ) u_scoreboard (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .set_i    (issue),
    .set_rd_i (out_rd_q),
    .clr_i    (bus.wb_valid),
    .clr_rd_i (bus.wb_rd),
    .busy_o   (sb_busy)
  );

  always_comb begin
    out_valid_d   = out_valid_q;
    out_opcode_d  = out_opcode_q;
    out_rd_d      = out_rd_q;
    out_rs1_d     = out_rs1_q;
    out_rs2_d     = out_rs2_q;
    out_addr_d    = out_addr_q;
    out_imm_d     = out_imm_q;
    out_wr_en_d   = out_wr_en_q;
    out_illegal_d = out_illegal_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      out_opcode_d  = dec_opcode;
      out_rd_d      = dec_rd;
      out_rs1_d     = dec_rs1;
      out_rs2_d     = dec_rs2;
      out_addr_d    = dec_addr;
      out_imm_d     = dec_imm;
      out_wr_en_d   = dec_wr_en;
      out_illegal_d = illegal;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_opcode_q  <= '0;
      out_rd_q      <= '0;
      out_rs1_q     <= '0;
      out_rs2_q     <= '0;
      out_addr_q    <= '0;
      out_imm_q     <= '0;
      out_wr_en_q   <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_opcode_q  <= out_opcode_d;
      out_rd_q      <= out_rd_d;
      out_rs1_q     <= out_rs1_d;
      out_rs2_q     <= out_rs2_d;
      out_addr_q    <= out_addr_d;
      out_imm_q     <= out_imm_d;
      out_wr_en_q   <= out_wr_en_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_opcode  = out_opcode_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_rs1     = out_rs1_q;
  assign bus.out_rs2     = out_rs2_q;
  assign bus.out_addr    = out_addr_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_wr_en   = out_wr_en_q;
  assign bus.out_illegal = out_illegal_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage at default parameters, plus a second instance with
// signed immediates. Expected values come from an instruction-level reference model:
// field extraction by arithmetic, a set of pending-write registers and one held slot.
module tb_instr_decode_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_decode_stage_if bus ();
  instr_decode_stage_if bus_s ();

  instr_decode_stage #(.IMM_SIGNED(1'b0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  instr_decode_stage #(.IMM_SIGNED(1'b1)) u_dut_signed (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [12:0] addr;
    logic [15:0] imm;
    logic        wr_en;
    logic        illegal;
  } fields_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit      m_valid;
  fields_t m_f;
  bit [7:0] m_busy;

  function automatic fields_t decode_ref(input logic [15:0] ins, input bit sgn);
    fields_t f;
    int v, o, rd, rs1, rs2, im;
    v   = int'(ins);
    o   = v / 8192;
    rd  = (v / 1024) % 8;
    rs1 = (v / 128) % 8;
    rs2 = (v / 16) % 8;
    im  = v % 1024;
    if (sgn && im >= 512) im = im + 65536 - 1024;
    f = '0;
    f.opcode = 3'(o);
    case (o)
      0, 7: begin f.rd = 3'(rd); f.rs1 = 3'(rd); f.imm = 16'(im); f.wr_en = 1'b1; end
      1:    begin f.rd = 3'(rd); f.rs1 = 3'(rs1); f.wr_en = 1'b1; end
      3:    begin f.rd = 3'(rd); f.rs1 = 3'(rs1); end
      2, 4: begin f.rd = 3'(rd); f.rs1 = 3'(rs1); f.rs2 = 3'(rs2); f.wr_en = 1'b1; end
      default: f.addr = 13'(v % 8192);
    endcase
    return f;
  endfunction

  // Registers an instruction reads, as a bit set
  function automatic bit [7:0] src_mask(input logic [15:0] ins);
    int v, rd, rs1, rs2;
    bit [7:0] m;
    v   = int'(ins);
    rd  = (v / 1024) % 8;
    rs1 = (v / 128) % 8;
    rs2 = (v / 16) % 8;
    m   = '0;
    case (v / 8192)
      1:       m[rs1] = 1'b1;
      2, 4:    begin m[rs1] = 1'b1; m[rs2] = 1'b1; end
      3:       begin m[rd] = 1'b1; m[rs1] = 1'b1; end
      7:       m[rd] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic bit ref_ready(input bit v, input logic [15:0] ins, input bit ordy,
                                   input bit fl);
    bit [7:0] pend;
    bit stall;
    pend = m_busy;
    if (m_valid && m_f.wr_en) pend[m_f.rd] = 1'b1;
    stall = v && ((src_mask(ins) & pend) != 8'h00);
    return rst_n && !fl && !stall && (!m_valid || ordy);
  endfunction

  function automatic fields_t dut_fields();
    return {bus.out_opcode, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_addr, bus.out_imm,
            bus.out_wr_en, bus.out_illegal};
  endfunction

  task automatic drive(input bit v, input logic [15:0] ins, input bit ordy, input bit wv,
                       input logic [2:0] wrd, input bit fl);
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.out_ready = ordy;
    bus.wb_valid  = wv;
    bus.wb_rd     = wrd;
    bus.flush     = fl;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_f     = '0;
    m_busy  = '0;
  endtask

  // Advance one clock, updating the model from the inputs held across the edge.
  task automatic tick();
    bit v, ordy, wv, fl, acc, iss;
    logic [15:0] ins;
    logic [2:0] wrd;
    v = bus.in_valid; ins = bus.instr; ordy = bus.out_ready;
    wv = bus.wb_valid; wrd = bus.wb_rd; fl = bus.flush;
    acc = v && ref_ready(v, ins, ordy, fl);
    iss = m_valid && ordy && !fl && m_f.wr_en;
    @(posedge clk);
    if (wv) m_busy[wrd] = 1'b0;
    if (iss) m_busy[m_f.rd] = 1'b1;
    if (fl) m_valid = 1'b0;
    else if (acc) begin m_valid = 1'b1; m_f = decode_ref(ins, 1'b0); end
    else if (ordy) m_valid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    bus_s.in_valid = 1'b0; bus_s.instr = '0; bus_s.out_ready = 1'b0;
    bus_s.wb_valid = 1'b0; bus_s.wb_rd = '0; bus_s.flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(1'b1, 16'h0805, 1'b1, 1'b0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (dut_fields() !== fields_t'('0)) begin
      errors++; $display("FAIL reset_fields: got %h expected 0", dut_fields());
    end
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_set_modex();
    do_reset();
    drive(1'b1, 16'h0805, 1'b0, 1'b0, 3'd0, 1'b0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL set_in_ready: got %b expected 1", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || dut_fields() !== m_f) begin
      errors++; $display("FAIL set_fields: got v=%b %h expected v=1 %h", bus.out_valid,
                         dut_fields(), m_f);
    end
    checks++;
    if (bus.out_rd !== 3'd2 || bus.out_imm !== 16'h0005 || bus.out_wr_en !== 1'b1 ||
        bus.out_addr !== 13'h0) begin
      errors++; $display("FAIL set_consts: got rd=%0d imm=%h wr=%b addr=%h expected 2 0005 1 0",
                         bus.out_rd, bus.out_imm, bus.out_wr_en, bus.out_addr);
    end
    do_reset();
    drive(1'b1, 16'h4530, 1'b1, 1'b0, 3'd0, 1'b0);
    #1;
    tick();
    checks++;
    if (bus.out_rd !== 3'd1 || bus.out_rs1 !== 3'd2 || bus.out_rs2 !== 3'd3 ||
        bus.out_imm !== 16'h0 || bus.out_wr_en !== 1'b1 || dut_fields() !== m_f) begin
      errors++; $display("FAIL modex_fields: got %h expected %h", dut_fields(), m_f);
    end
  endtask

  task automatic test_imm_signed();
    do_reset();
    bus_s.in_valid = 1'b1;
    bus_s.instr    = 16'h0BFF;
    #1;
    checks++;
    if (bus_s.in_ready !== 1'b1) begin
      errors++; $display("FAIL signed_in_ready: got %b expected 1", bus_s.in_ready);
    end
    @(posedge clk);
    #1;
    bus_s.in_valid = 1'b0;
    checks++;
    if (bus_s.out_valid !== 1'b1 || bus_s.out_imm !== decode_ref(16'h0BFF, 1'b1).imm ||
        bus_s.out_imm !== 16'hFFFF) begin
      errors++; $display("FAIL signed_imm: got v=%b imm=%h expected v=1 imm=ffff",
                         bus_s.out_valid, bus_s.out_imm);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ins;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ins = (i == 0) ? 16'hDABC : {3'b110, 13'($urandom)};
      drive(1'b1, ins, 1'b1, 1'b0, 3'd0, 1'b0);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || dut_fields() !== m_f || bus.out_wr_en !== 1'b0) begin
        errors++; $display("FAIL b2b_fields[%0d]: got v=%b %h expected v=1 %h", i,
                           bus.out_valid, dut_fields(), m_f);
      end
    end
    checks++;
    if (bus.out_addr !== 13'(ins)) begin
      errors++; $display("FAIL b2b_last_addr: got %h expected %h", bus.out_addr, 13'(ins));
    end
  endtask

  task automatic test_raw();
    do_reset();
    drive(1'b1, 16'h0805, 1'b1, 1'b0, 3'd0, 1'b0);
    #1;
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'hE801, 1'b1, 1'b0, 3'd0, 1'b0);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || ref_ready(1'b1, 16'hE801, 1'b1, 1'b0) !== 1'b0) begin
        errors++; $display("FAIL raw_stall[%0d]: got %b expected 0", i, bus.in_ready);
      end
      tick();
    end
    drive(1'b1, 16'hE801, 1'b1, 1'b1, 3'd2, 1'b0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL raw_wb_cycle: got %b expected 0", bus.in_ready);
    end
    tick();
    drive(1'b1, 16'hE801, 1'b1, 1'b0, 3'd0, 1'b0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL raw_after_wb: got %b expected 1", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || dut_fields() !== m_f || bus.out_opcode !== 3'd7 ||
        bus.out_imm !== 16'h1) begin
      errors++; $display("FAIL raw_add_fields: got %h expected %h", dut_fields(), m_f);
    end
  endtask

  task automatic test_backpressure();
    fields_t first;
    do_reset();
    first = decode_ref(16'hC123, 1'b0);
    drive(1'b1, 16'hC123, 1'b0, 1'b0, 3'd0, 1'b0);
    #1;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'hA456, 1'b0, 1'b0, 3'd0, 1'b0);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || dut_fields() !== first) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b %h expected v=1 %h", i,
                           bus.out_valid, dut_fields(), first);
      end
    end
    drive(1'b1, 16'hA456, 1'b1, 1'b0, 3'd0, 1'b0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got %b expected 1", bus.in_ready);
    end
    tick();
    checks++;
    if (dut_fields() !== decode_ref(16'hA456, 1'b0) || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_second: got %h expected %h", dut_fields(),
                         decode_ref(16'hA456, 1'b0));
    end
    drive(1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 1'b0);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 16'h0805, 1'b0, 1'b0, 3'd0, 1'b0);
    #1;
    tick();
    drive(1'b1, 16'hDABC, 1'b1, 1'b0, 3'd0, 1'b1);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_out_valid: got %b expected 0", bus.out_valid);
    end
    drive(1'b1, 16'hE801, 1'b1, 1'b0, 3'd0, 1'b0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_no_sb: got %b expected 1", bus.in_ready);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 16'h0805, 1'b1, 1'b0, 3'd0, 1'b0);
    #1;
    tick();
    drive(1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 1'b0);
    tick();
    drive(1'b1, 16'hE801, 1'b1, 1'b0, 3'd0, 1'b0);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_async: got ready=%b valid=%b expected 0 0",
                         bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_sb_lost: got %b expected 1", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || dut_fields() !== m_f) begin
      errors++; $display("FAIL midreset_accept: got %h expected %h", dut_fields(), m_f);
    end
  endtask

  task automatic test_random();
    bit v, ordy, wv, fl, exp_r;
    logic [15:0] ins;
    logic [2:0] wrd;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v    = ($urandom % 10) < 7;
      ins  = 16'($urandom);
      ordy = ($urandom % 10) < 7;
      fl   = ($urandom % 20) == 0;
      wv   = ($urandom % 3) == 0;
      wrd  = 3'($urandom);
      if (wv && m_busy != 8'h00) begin
        while (!m_busy[wrd]) wrd = wrd + 3'd1;
      end
      drive(v, ins, ordy, wv, wrd, fl);
      #1;
      exp_r = ref_ready(v, ins, ordy, fl);
      checks++;
      if (bus.in_ready !== exp_r) begin
        errors++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", i, bus.in_ready,
                           exp_r);
      end
      tick();
      checks++;
      if (bus.out_valid !== m_valid) begin
        errors++; $display("FAIL rand_out_valid[%0d]: got %b expected %b", i, bus.out_valid,
                           m_valid);
      end
      if (m_valid) begin
        checks++;
        if (dut_fields() !== m_f) begin
          errors++; $display("FAIL rand_fields[%0d]: got %h expected %h", i, dut_fields(),
                             m_f);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 1'b0);
    bus_s.in_valid = 1'b0; bus_s.instr = '0; bus_s.out_ready = 1'b0;
    bus_s.wb_valid = 1'b0; bus_s.wb_rd = '0; bus_s.flush = 1'b0;
    #1;
    test_reset();
    test_set_modex();
    test_imm_signed();
    test_back_to_back();
    test_raw();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
